config_arbiter: RTL and testbench
=================================

CONFIG_ARBITER -- requirements
Module: config_arbiter

Interface
REQ-001 Parameter WIDTH_CONFIG_ADDR, default 4, config address width.
REQ-002 Parameter WIDTH_CONFIG_DATA, default 8, config data width.
REQ-003 Parameter TIMEOUT, default 255, max BUSY cycles waiting for target ready; legal range 1..255, counter 8 bits.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 req0_addr / req1_addr  in  WIDTH_CONFIG_ADDR  requester config address.
REQ-007 req0_data / req1_data  in  WIDTH_CONFIG_DATA  requester config data.
REQ-008 req0_valid / req1_valid  in  1  requester has a write pending; addr/data held stable until matching ready.
REQ-009 req0_ready / req1_ready  out  1  one-cycle accept pulse to requester.
REQ-010 c_addr  out  WIDTH_CONFIG_ADDR  config bus address (01xx UART, 10xx VGA).
REQ-011 c_data  out  WIDTH_CONFIG_DATA  config bus data.
REQ-012 c_valid  out  1  config bus write valid.
REQ-013 uart_ready / vga_ready  in  1  c_ready from UART / VGA configuration blocks.
REQ-014 grant_id  out  1  requester owning the current transfer.
REQ-015 busy  out  1  high while in BUSY.
REQ-016 addr_err / timeout_err  out  1  one-cycle error pulses.

Function
REQ-017 FSM states: IDLE, BUSY; 1-bit last_grant register.
REQ-018 IDLE, no valid: stay IDLE; all pulses low.
REQ-019 IDLE, exactly one valid: grant it; both valid: grant requester != last_grant.
REQ-020 Grant cycle: reqN_ready=1 combinationally (state==IDLE and granted); addr/data captured into c_addr/c_data registers, grant_id and last_grant updated on that edge.
REQ-021 Decode captured addr[top two bits]: 01 -> UART target, 10 -> VGA target, 00/11 -> invalid.
REQ-022 Invalid target: stay IDLE, addr_err=1 next cycle, c_valid stays 0; requester already acked.
REQ-023 Valid target: enter BUSY next cycle with c_valid=1, busy=1, timeout counter=0.
REQ-024 BUSY: transfer completes in the cycle c_valid=1 and selected target ready=1; next cycle c_valid=0, state IDLE.
REQ-025 Unselected target's ready is ignored.
REQ-026 c_addr/c_data stable throughout BUSY.
REQ-027 BUSY counter increments each cycle without ready; at count==TIMEOUT-1 with no ready: next cycle c_valid=0, IDLE, timeout_err=1 for one cycle.
REQ-028 Ready and timeout in same cycle: transfer counts as complete, no timeout_err.
REQ-029 No arbitration in BUSY; requests wait; reqN_ready never asserted in BUSY.
REQ-030 Throughput: max one transfer per 2 cycles (grant cycle + ≥1 BUSY cycle).
REQ-031 c_valid, once high, never drops before completion or timeout.

Reset
REQ-032 rst_n low: state IDLE, c_valid=0, c_addr=0, c_data=0, grant_id=0, busy=0, addr_err=0, timeout_err=0, counter=0, last_grant=1 (req0 wins first tie).
REQ-033 Reset during BUSY aborts the transfer silently; no error pulse after release.
REQ-034 reqN_ready=0 while rst_n low.

Structure
REQ-035 Target region codes (01 UART, 10 VGA) and state encodings in the shared CS parameter header.
REQ-036 Optional sub-module cfg_rr_pick: 2-way round-robin grant from valids and last_grant, purely combinational.

Verification
REQ-037 req0 valid, addr 0x4, data 0x03, uart_ready=1 -> req0_ready at T0, c_valid T1..T1, c_addr=0x4, c_data=0x03, IDLE at T2.
REQ-038 Both valid from reset, both repeatedly -> grants alternate 0,1,0,1; no starvation.
REQ-039 req1 addr 0x8, vga_ready low 3 cycles, uart_ready high -> c_valid held 4 cycles, completes on vga_ready.
REQ-040 req0 addr 0x0 -> req0_ready pulse, addr_err next cycle, c_valid never high.
REQ-041 TIMEOUT=4, target ready never high -> c_valid 4 cycles, then timeout_err one cycle, IDLE.
REQ-042 rst_n low mid-BUSY -> all outputs 0 asynchronously; after release next grant goes to req0.

Source files
------------

// File: rtl/config_arbiter_pkg.sv
// config_arbiter_pkg: shared target region codes, FSM state encoding and decode helper
package config_arbiter_pkg;
  typedef enum logic {IDLE, BUSY} state_t;
  localparam logic [1:0] REGION_UART = 2'b01;
  localparam logic [1:0] REGION_VGA = 2'b10;
  localparam int CNT_W = 8;
  function automatic logic region_ok(input logic [1:0] region);
    return region == REGION_UART || region == REGION_VGA;
  endfunction
endpackage

// File: rtl/config_arbiter_rr_pick.sv
// config_arbiter_rr_pick: combinational 2-way round-robin pick from valids and last grant
module config_arbiter_rr_pick (
  input  logic valid0,
  input  logic valid1,
  input  logic last_grant,
  output logic any,
  output logic grant
);
  always_comb begin
    any = valid0 | valid1;
    grant = (valid0 & valid1) ? ~last_grant : valid1;
  end
endmodule

// File: rtl/config_arbiter.sv
// config_arbiter: arbitrates two config write requesters onto a shared UART/VGA config bus
module config_arbiter
  import config_arbiter_pkg::*;
#(
  parameter int WIDTH_CONFIG_ADDR = 4,
  parameter int WIDTH_CONFIG_DATA = 8,
  parameter int TIMEOUT = 255
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [WIDTH_CONFIG_ADDR-1:0] req0_addr,
  input  logic [WIDTH_CONFIG_DATA-1:0] req0_data,
  input  logic                         req0_valid,
  output logic                         req0_ready,
  input  logic [WIDTH_CONFIG_ADDR-1:0] req1_addr,
  input  logic [WIDTH_CONFIG_DATA-1:0] req1_data,
  input  logic                         req1_valid,
  output logic                         req1_ready,
  output logic [WIDTH_CONFIG_ADDR-1:0] c_addr,
  output logic [WIDTH_CONFIG_DATA-1:0] c_data,
  output logic                         c_valid,
  input  logic                         uart_ready,
  input  logic                         vga_ready,
  output logic                         grant_id,
  output logic                         busy,
  output logic                         addr_err,
  output logic                         timeout_err
);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);
  state_t state;
  logic [CNT_W-1:0] cnt;
  logic last_grant, tgt_vga, any, pick, grant_now, target_rdy;
  logic [WIDTH_CONFIG_ADDR-1:0] sel_addr;
  logic [WIDTH_CONFIG_DATA-1:0] sel_data;
  logic [1:0] region;
  config_arbiter_rr_pick u_pick (
    .valid0(req0_valid),
    .valid1(req1_valid),
    .last_grant(last_grant),
    .any(any),
    .grant(pick)
  );
  always_comb begin
    sel_addr = pick ? req1_addr : req0_addr;
    sel_data = pick ? req1_data : req0_data;
    region = sel_addr[WIDTH_CONFIG_ADDR-1 -: 2];
    target_rdy = tgt_vga ? vga_ready : uart_ready;
    grant_now = rst_n && state == IDLE && any;
    req0_ready = grant_now && !pick;
    req1_ready = grant_now && pick;
  end
  // Invalid regions are still acked and captured; only the bus write is suppressed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      last_grant <= 1'b1;
      tgt_vga <= 1'b0;
      c_addr <= '0;
      c_data <= '0;
      c_valid <= 1'b0;
      grant_id <= 1'b0;
      busy <= 1'b0;
      addr_err <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      addr_err <= 1'b0;
      timeout_err <= 1'b0;
      if (state == IDLE) begin
        if (any) begin
          c_addr <= sel_addr;
          c_data <= sel_data;
          grant_id <= pick;
          last_grant <= pick;
          tgt_vga <= region == REGION_VGA;
          cnt <= '0;
          if (region_ok(region)) begin
            state <= BUSY;
            c_valid <= 1'b1;
            busy <= 1'b1;
          end else begin
            addr_err <= 1'b1;
          end
        end
      end else if (target_rdy || cnt == TIMEOUT_LAST) begin
        state <= IDLE;
        c_valid <= 1'b0;
        busy <= 1'b0;
        timeout_err <= !target_rdy;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_config_arbiter.sv
// tb_config_arbiter: directed stimulus with a transfer-level reference model checked every cycle
module tb_config_arbiter;
  localparam int TO = 4;
  logic clk = 1'b0;
  logic rst_n;
  logic [3:0] req0_addr, req1_addr, c_addr;
  logic [7:0] req0_data, req1_data, c_data;
  logic req0_valid, req1_valid, req0_ready, req1_ready;
  logic c_valid, uart_ready, vga_ready, grant_id, busy, addr_err, timeout_err;
  int n_cmp = 0;
  int n_bad = 0;

  config_arbiter #(.WIDTH_CONFIG_ADDR(4), .WIDTH_CONFIG_DATA(8), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_addr(req0_addr), .req0_data(req0_data), .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req1_addr(req1_addr), .req1_data(req1_data), .req1_valid(req1_valid), .req1_ready(req1_ready),
    .c_addr(c_addr), .c_data(c_data), .c_valid(c_valid),
    .uart_ready(uart_ready), .vga_ready(vga_ready),
    .grant_id(grant_id), .busy(busy), .addr_err(addr_err), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: one transfer at a time, described by how long it has waited.
  bit m_act, m_vga, m_gid, m_last, m_aerr, m_terr;
  int m_age;
  logic [3:0] m_addr;
  logic [7:0] m_data;

  function automatic bit win(input bit v0, input bit v1, input bit last);
    if (v0 && v1) return !last;
    return v1;
  endfunction

  function automatic bit legal(input logic [3:0] a);
    return a[3:2] == 2'b01 || a[3:2] == 2'b10;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_act <= 0; m_vga <= 0; m_gid <= 0; m_last <= 1; m_aerr <= 0; m_terr <= 0;
      m_age <= 0; m_addr <= 0; m_data <= 0;
    end else begin
      m_aerr <= 0;
      m_terr <= 0;
      if (m_act) begin
        if (m_vga ? vga_ready : uart_ready) m_act <= 0;
        else if (m_age + 1 >= TO) begin m_act <= 0; m_terr <= 1; end
        else m_age <= m_age + 1;
      end else if (req0_valid || req1_valid) begin
        m_gid <= win(req0_valid, req1_valid, m_last);
        m_last <= win(req0_valid, req1_valid, m_last);
        m_addr <= win(req0_valid, req1_valid, m_last) ? req1_addr : req0_addr;
        m_data <= win(req0_valid, req1_valid, m_last) ? req1_data : req0_data;
        if (legal(win(req0_valid, req1_valid, m_last) ? req1_addr : req0_addr)) begin
          m_act <= 1;
          m_age <= 0;
          m_vga <= (win(req0_valid, req1_valid, m_last) ? req1_addr[3:2] : req0_addr[3:2]) == 2'b10;
        end else m_aerr <= 1;
      end
    end
  end

  always @(negedge clk) begin
    bit g, w;
    g = rst_n && !m_act && (req0_valid || req1_valid);
    w = win(req0_valid, req1_valid, m_last);
    chk("req0_ready", req0_ready, g && !w);
    chk("req1_ready", req1_ready, g && w);
    chk("c_valid", c_valid, m_act);
    chk("busy", busy, m_act);
    chk("c_addr", c_addr, m_addr);
    chk("c_data", c_data, m_data);
    chk("grant_id", grant_id, m_gid);
    chk("addr_err", addr_err, m_aerr);
    chk("timeout_err", timeout_err, m_terr);
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic look();
    @(negedge clk);
    #1;
  endtask

  initial begin
    rst_n = 0;
    req0_valid = 0; req1_valid = 0; req0_addr = 0; req1_addr = 0; req0_data = 0; req1_data = 0;
    uart_ready = 0; vga_ready = 0;
    look();
    chk("rst c_valid", c_valid, 0);
    chk("rst grant_id", grant_id, 0);
    chk("rst busy", busy, 0);
    chk("rst req0_ready", req0_ready, 0);
    cyc();
    rst_n = 1;
    // both requesters permanently pending: grants must alternate starting with req0
    req0_valid = 1; req0_addr = 4'h4; req0_data = 8'hA0;
    req1_valid = 1; req1_addr = 4'h5; req1_data = 8'hB1;
    uart_ready = 1;
    for (int i = 0; i < 4; i++) begin
      look();
      chk("alt req0_ready", req0_ready, (i % 2) == 0);
      chk("alt req1_ready", req1_ready, (i % 2) == 1);
      cyc();
      look();
      chk("alt grant_id", grant_id, i % 2);
      chk("alt c_data", c_data, (i % 2) ? 8'hB1 : 8'hA0);
      chk("alt no ready in busy", req0_ready | req1_ready, 0);
      cyc();
    end
    req0_valid = 0; req1_valid = 0;
    cyc();
    // single uart write
    req0_valid = 1; req0_addr = 4'h4; req0_data = 8'h03;
    look();
    chk("uart req0_ready T0", req0_ready, 1);
    chk("uart c_valid T0", c_valid, 0);
    cyc();
    req0_valid = 0;
    look();
    chk("uart c_valid T1", c_valid, 1);
    chk("uart c_addr T1", c_addr, 4'h4);
    chk("uart c_data T1", c_data, 8'h03);
    cyc();
    look();
    chk("uart c_valid T2", c_valid, 0);
    chk("uart busy T2", busy, 0);
    cyc();
    // vga write held off by vga_ready for three cycles, uart_ready ignored
    req1_valid = 1; req1_addr = 4'h8; req1_data = 8'h5A; vga_ready = 0; uart_ready = 1;
    look();
    chk("vga req1_ready", req1_ready, 1);
    cyc();
    req1_valid = 0;
    for (int i = 0; i < 3; i++) begin
      look();
      chk("vga c_valid wait", c_valid, 1);
      cyc();
    end
    vga_ready = 1;
    look();
    chk("vga c_valid last", c_valid, 1);
    cyc();
    vga_ready = 0;
    look();
    chk("vga done", c_valid, 0);
    cyc();
    // invalid regions 00 and 11
    req0_valid = 1; req0_addr = 4'h0; req0_data = 8'h11;
    look();
    chk("inv0 req0_ready", req0_ready, 1);
    cyc();
    req0_valid = 0;
    look();
    chk("inv0 addr_err", addr_err, 1);
    chk("inv0 c_valid", c_valid, 0);
    cyc();
    req1_valid = 1; req1_addr = 4'hC; req1_data = 8'h22;
    look();
    chk("inv0 addr_err clear", addr_err, 0);
    chk("inv3 req1_ready", req1_ready, 1);
    cyc();
    req1_valid = 0;
    look();
    chk("inv3 addr_err", addr_err, 1);
    chk("inv3 grant_id", grant_id, 1);
    cyc();
    cyc();
    // timeout on uart with only the unselected vga ready asserted
    uart_ready = 0; vga_ready = 1;
    req0_valid = 1; req0_addr = 4'h6; req0_data = 8'h33;
    cyc();
    req0_valid = 0;
    for (int i = 0; i < TO; i++) begin
      look();
      chk("to c_valid", c_valid, 1);
      cyc();
    end
    look();
    chk("to timeout_err", timeout_err, 1);
    chk("to c_valid off", c_valid, 0);
    cyc();
    look();
    chk("to timeout_err clear", timeout_err, 0);
    cyc();
    // ready arriving in the last allowed cycle wins over timeout
    vga_ready = 0;
    req1_valid = 1; req1_addr = 4'h9; req1_data = 8'h44;
    cyc();
    req1_valid = 0;
    repeat (TO - 1) cyc();
    vga_ready = 1;
    cyc();
    vga_ready = 0;
    look();
    chk("late ready no timeout_err", timeout_err, 0);
    chk("late ready c_valid", c_valid, 0);
    cyc();
    // reset in the middle of a transfer
    req0_valid = 1; req0_addr = 4'h4; req0_data = 8'h55; uart_ready = 0;
    cyc();
    req0_valid = 0;
    cyc();
    req0_valid = 1; req1_valid = 1; req1_addr = 4'h8; req1_data = 8'h66; vga_ready = 1;
    #1 rst_n = 0;
    #1;
    chk("arst c_valid", c_valid, 0);
    chk("arst busy", busy, 0);
    chk("arst c_addr", c_addr, 0);
    chk("arst c_data", c_data, 0);
    chk("arst req0_ready", req0_ready, 0);
    chk("arst req1_ready", req1_ready, 0);
    cyc();
    cyc();
    rst_n = 1;
    look();
    chk("post rst req0_ready", req0_ready, 1);
    chk("post rst req1_ready", req1_ready, 0);
    chk("post rst timeout_err", timeout_err, 0);
    cyc();
    req0_valid = 0;
    uart_ready = 1;
    repeat (4) cyc();
    req1_valid = 0;
    repeat (3) cyc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
